vchip8_debug_scan_master: RTL and testbench

Single-clock initiator for the Nios II debug slave's virtual-JTAG interface. It accepts a 2-bit IR and a 38-bit DR command on a valid/ready port and generates the full scan sequence on the slave-side pins: IR update, capture, 38 shifts and DR update. It drives `tck`, `tdi`, `ir_in`, `vs_uir`, `vs_cdr`, `vs_sdr`, `vs_udr` and `jtag_state_rti`, and samples `tdo`. The captured 38-bit shift-out is returned on a response port. Used for on-chip self-test and simulation of the vChip8 CPU debug path without an external JTAG hub.

---
 rtl/vchip8_debug_scan_master.sv | 165 ++++++++++++++++
 tb/tb_vchip8_debug_scan_master.sv | 392 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vchip8_debug_scan_master.sv
// ---------------------------------------------------------------------------
// vchip8_debug_scan_master
//
// Single-clock initiator for the Nios II debug slave's virtual-JTAG pins.
// One command (2-bit IR + DR_W-bit DR) is accepted on a valid/ready port.
// The block then plays the slave-side sequence
//   IDLE -> UIR -> CDR -> SHIFT (DR_W tck periods) -> UDR -> RSP -> IDLE.
// The DR_W bits captured from tdo are returned on the response port.
//
// Ports
//   clk             system clock, rising edge
//   reset           synchronous, active-high
//   cmd_valid/ready command handshake; cmd_ready is high only in IDLE
//   cmd_ir          IR value presented on ir_in for the whole scan
//   cmd_data        DR value, shifted out LSB first on tdi
//   rsp_valid       one-cycle pulse, rsp_data valid (held until next RSP)
//   rsp_data        captured tdo bits, first-shifted bit in bit 0
//   tck             generated scan clock (low half, then high half)
//   tdi / tdo       serial data to / from the slave
//   ir_in           IR presented to the slave
//   vs_uir/cdr/sdr/udr  virtual state qualifiers, one per scan phase
//   jtag_state_rti  high in IDLE and RSP
//   busy            high from command accept through rsp_valid
//
// Every output is a flop: control outputs are registered from the
// next-state decode so they line up with the state they describe.
// ---------------------------------------------------------------------------
module vchip8_debug_scan_master #(
    parameter int TCK_HALF = 2,   // tck half-period in clk cycles, 1..255
    parameter int DR_W     = 38   // data-register scan length
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [1:0]      cmd_ir,
    input  logic [DR_W-1:0] cmd_data,
    output logic            rsp_valid,
    output logic [DR_W-1:0] rsp_data,
    output logic            tck,
    output logic            tdi,
    input  logic            tdo,
    output logic [1:0]      ir_in,
    output logic            vs_uir,
    output logic            vs_cdr,
    output logic            vs_sdr,
    output logic            vs_udr,
    output logic            jtag_state_rti,
    output logic            busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_UIR   = 3'd1;
    localparam logic [2:0] S_CDR   = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_UDR   = 3'd4;
    localparam logic [2:0] S_RSP   = 3'd5;

    // The divider counts clk cycles within one tck half; tck itself is the
    // phase bit, so an 8-bit counter covers the full 1..255 range.
    localparam logic [7:0] DIV_LAST = 8'(TCK_HALF - 1);
    localparam logic [5:0] BIT_LAST = 6'(DR_W - 1);

    logic [2:0]      state, state_nxt;
    logic [7:0]      div_cnt;
    logic [5:0]      bit_cnt;
    logic [DR_W-1:0] sr, sr_nxt;
    logic            tdo_smp;
    logic            scanning;
    logic            half_end;
    logic            period_end;
    logic            accept;

    assign scanning   = (state == S_UIR) || (state == S_CDR) ||
                        (state == S_SHIFT) || (state == S_UDR);
    assign half_end   = (div_cnt == DIV_LAST);
    assign period_end = half_end && tck;   // end of the high half
    assign accept     = (state == S_IDLE) && cmd_valid;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_nxt = state;
        sr_nxt    = sr;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_nxt = S_UIR;
                    sr_nxt    = cmd_data;
                end
            end
            S_UIR:   if (period_end) state_nxt = S_CDR;
            S_CDR:   if (period_end) state_nxt = S_SHIFT;
            S_SHIFT: begin
                if (period_end) begin
                    // Sample taken just before tck rose enters at the top.
                    sr_nxt = {tdo_smp, sr[DR_W-1:1]};
                    if (bit_cnt == BIT_LAST) state_nxt = S_UDR;
                end
            end
            S_UDR:   if (period_end) state_nxt = S_RSP;
            S_RSP:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            state          <= S_IDLE;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            tck            <= 1'b0;
            tdi            <= 1'b0;
            ir_in          <= '0;
            vs_uir         <= 1'b0;
            vs_cdr         <= 1'b0;
            vs_sdr         <= 1'b0;
            vs_udr         <= 1'b0;
            jtag_state_rti <= 1'b1;
            cmd_ready      <= 1'b1;
            busy           <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
        end else begin
            state <= state_nxt;

            if (scanning) begin
                div_cnt <= half_end ? 8'd0 : div_cnt + 8'd1;
                if (half_end) tck <= ~tck;
            end else begin
                div_cnt <= '0;
                tck     <= 1'b0;
            end

            if (state == S_SHIFT && period_end)
                bit_cnt <= (bit_cnt == BIT_LAST) ? 6'd0 : bit_cnt + 6'd1;

            if (accept) ir_in <= cmd_ir;   // held until the next command

            tdi            <= (state_nxt == S_SHIFT) & sr_nxt[0];
            vs_uir         <= (state_nxt == S_UIR);
            vs_cdr         <= (state_nxt == S_CDR);
            vs_sdr         <= (state_nxt == S_SHIFT);
            vs_udr         <= (state_nxt == S_UDR);
            jtag_state_rti <= (state_nxt == S_IDLE) || (state_nxt == S_RSP);
            cmd_ready      <= (state_nxt == S_IDLE);
            busy           <= (state_nxt != S_IDLE);
            rsp_valid      <= (state_nxt == S_RSP);

            // The shift register is final once SHIFT ends; latch it as RSP
            // is entered so rsp_data is valid alongside rsp_valid.
            if (state == S_UDR && period_end) rsp_data <= sr;
        end
    end

    // NOTE: the data path has no reset; the shift register is always loaded
    // at command accept and tdo_smp is written before it is ever consumed.
    always_ff @(posedge clk) begin
        sr <= sr_nxt;
        if (state == S_SHIFT && half_end && !tck) tdo_smp <= tdo;
    end

endmodule

// File: tb/tb_vchip8_debug_scan_master.sv
// ---------------------------------------------------------------------------
// tb_vchip8_debug_scan_master
//
// Drives two instances (TCK_HALF=2 and TCK_HALF=1) against behavioural
// slave models clocked by tck: a 1-bit loopback and a 38-bit stub shift
// register. Expected responses come from the slave's own rules:
//   loopback : rsp = (cmd_data << 1) | seed
//   stub     : rsp = preset, stub afterwards holds cmd_data
// Qualifier-gated tck rising edges are counted by monitors.
// ---------------------------------------------------------------------------
module tb_vchip8_debug_scan_master;

    localparam int DR = 38;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic          cmd_valid, cmd_valid1;
    logic [1:0]    cmd_ir;
    logic [DR-1:0] cmd_data;

    logic          cmd_ready, rsp_valid, tck, tdi, tdo;
    logic [DR-1:0] rsp_data;
    logic [1:0]    ir_in;
    logic          vs_uir, vs_cdr, vs_sdr, vs_udr, rti, busy;

    logic          cmd_ready1, rsp_valid1, tck1, tdi1, tdo1;
    logic [DR-1:0] rsp_data1;
    logic [1:0]    ir_in1;
    logic          vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1, busy1;

    vchip8_debug_scan_master #(.TCK_HALF(2), .DR_W(DR)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .tck(tck), .tdi(tdi), .tdo(tdo), .ir_in(ir_in),
        .vs_uir(vs_uir), .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr),
        .jtag_state_rti(rti), .busy(busy)
    );

    vchip8_debug_scan_master #(.TCK_HALF(1), .DR_W(DR)) dut1 (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1),
        .tck(tck1), .tdi(tdi1), .tdo(tdo1), .ir_in(ir_in1),
        .vs_uir(vs_uir1), .vs_cdr(vs_cdr1), .vs_sdr(vs_sdr1), .vs_udr(vs_udr1),
        .jtag_state_rti(rti1), .busy(busy1)
    );

    // ---------------- slave models (clocked by tck) ----------------
    logic          use_stub;
    logic          loop_seed;
    logic [DR-1:0] stub_preset;
    logic [DR-1:0] stub;
    logic          loop_q, loop1_q;

    always @(posedge tck) begin
        if (vs_cdr) begin
            loop_q <= loop_seed;
            stub   <= stub_preset;
        end else if (vs_sdr) begin
            loop_q <= tdi;
            stub   <= {tdi, stub[DR-1:1]};
        end
    end
    assign tdo = use_stub ? stub[0] : loop_q;

    always @(posedge tck1) begin
        if (vs_cdr1)      loop1_q <= loop_seed;
        else if (vs_sdr1) loop1_q <= tdi1;
    end
    assign tdo1 = loop1_q;

    // ---------------- monitors ----------------
    int n_uir = 0, n_cdr = 0, n_sdr = 0, n_udr = 0;
    always @(posedge tck) begin
        if (vs_uir) n_uir++;
        if (vs_cdr) n_cdr++;
        if (vs_sdr) n_sdr++;
        if (vs_udr) n_udr++;
    end

    int n_sdr1 = 0;
    always @(posedge tck1) if (vs_sdr1) n_sdr1++;

    logic [1:0] exp_ir = 2'd0;
    int ir_bad = 0, tdi_bad = 0, n_rsp = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if ((vs_uir | vs_cdr | vs_sdr | vs_udr) && ir_in !== exp_ir) ir_bad++;
            if (!vs_sdr && tdi !== 1'b0) tdi_bad++;
            if (rsp_valid) n_rsp++;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Packed view of the control outputs for reset-value comparisons.
    function automatic logic [11:0] outs0();
        return {tck, tdi, ir_in, vs_uir, vs_cdr, vs_sdr, vs_udr, rti, cmd_ready, busy, rsp_valid};
    endfunction
    function automatic logic [11:0] outs1();
        return {tck1, tdi1, ir_in1, vs_uir1, vs_cdr1, vs_sdr1, vs_udr1, rti1, cmd_ready1, busy1, rsp_valid1};
    endfunction
    localparam logic [11:0] RST_OUTS = 12'b0000_0000_1100;

    // Issue one command (caller is at a negedge with the target idle) and
    // wait for its response; lat is handshake sample to rsp sample in cycles.
    task automatic run_scan(input bit sel, input logic [1:0] ir, input logic [DR-1:0] data,
                            output logic [DR-1:0] rsp, output int lat);
        cmd_ir   = ir;
        cmd_data = data;
        if (!sel) exp_ir = ir;
        if (sel) cmd_valid1 = 1'b1; else cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid  = 1'b0;
        cmd_valid1 = 1'b0;
        lat = 1;
        while (((sel ? rsp_valid1 : rsp_valid) !== 1'b1) && lat < 2000) begin
            @(negedge clk);
            lat++;
        end
        rsp = sel ? rsp_data1 : rsp_data;
    endtask

    function automatic logic [DR-1:0] loop_expect(input logic [DR-1:0] d, input logic seed);
        return (d << 1) | DR'(seed);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (outs0() !== RST_OUTS || rsp_data !== '0) begin
            n_fail++;
            $display("FAIL reset_values: outs=%b rsp_data=%h, want outs=%b rsp_data=0", outs0(), rsp_data, RST_OUTS);
        end
        n_checks++;
        if (outs1() !== RST_OUTS || rsp_data1 !== '0) begin
            n_fail++;
            $display("FAIL reset_values_th1: outs=%b rsp_data=%h, want outs=%b rsp_data=0", outs1(), rsp_data1, RST_OUTS);
        end
        for (int i = 0; i < 20; i++) begin
            n_checks++;
            if ({cmd_ready, rti, tck, vs_uir, vs_cdr, vs_sdr, vs_udr} !== 7'b1100000) begin
                n_fail++;
                $display("FAIL idle_cycle_%0d: ready/rti/tck/vs=%b, want 1100000", i,
                         {cmd_ready, rti, tck, vs_uir, vs_cdr, vs_sdr, vs_udr});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_loopback();
        logic [DR-1:0] d, r, e;
        int lat, u0, c0, s0, d0, ib0, tb0;
        use_stub = 1'b0;
        loop_seed = 1'b1;
        d = 38'h2A_5A5A_5A5A;
        e = loop_expect(d, 1'b1);
        u0 = n_uir; c0 = n_cdr; s0 = n_sdr; d0 = n_udr; ib0 = ir_bad; tb0 = tdi_bad;
        run_scan(1'b0, 2'd2, d, r, lat);
        n_checks++;
        if (lat != 165) begin n_fail++; $display("FAIL loop_latency: got %0d want 165", lat); end
        n_checks++;
        if (r !== e) begin n_fail++; $display("FAIL loop_rsp_data: got %h want %h", r, e); end
        n_checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++; $display("FAIL loop_rsp_flags: ready=%b busy=%b want ready=0 busy=1", cmd_ready, busy);
        end
        @(negedge clk);
        n_checks++;
        if ({n_uir - u0, n_cdr - c0, n_sdr - s0, n_udr - d0} !== {32'd1, 32'd1, 32'd38, 32'd1}) begin
            n_fail++;
            $display("FAIL loop_tck_edges: uir=%0d cdr=%0d sdr=%0d udr=%0d want 1/1/38/1",
                     n_uir - u0, n_cdr - c0, n_sdr - s0, n_udr - d0);
        end
        n_checks++;
        if (ir_bad != ib0 || tdi_bad != tb0) begin
            n_fail++; $display("FAIL loop_ir_tdi: ir errors %0d tdi errors %0d want 0/0", ir_bad - ib0, tdi_bad - tb0);
        end
        n_checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0 || rsp_valid !== 1'b0 || ir_in !== 2'd2 || rti !== 1'b1) begin
            n_fail++;
            $display("FAIL loop_after: ready=%b busy=%b rsp_valid=%b ir_in=%0d rti=%b want 1/0/0/2/1",
                     cmd_ready, busy, rsp_valid, ir_in, rti);
        end
        n_checks++;
        if (rsp_data !== e) begin n_fail++; $display("FAIL loop_rsp_hold: got %h want %h", rsp_data, e); end
    endtask

    task automatic test_stub();
        logic [DR-1:0] d, r;
        int lat;
        use_stub = 1'b1;
        stub_preset = 38'h3F_0000_00FF;
        d = {6'($urandom), 32'($urandom)};
        run_scan(1'b0, 2'd1, d, r, lat);
        n_checks++;
        if (r !== 38'h3F_0000_00FF) begin n_fail++; $display("FAIL stub_rsp: got %h want 3f000000ff", r); end
        @(negedge clk);
        n_checks++;
        if (stub !== d) begin n_fail++; $display("FAIL stub_contents: got %h want %h", stub, d); end
        use_stub = 1'b0;
    endtask

    task automatic test_latency_th1();
        logic [DR-1:0] d, r, e;
        int lat, s0;
        loop_seed = 1'b0;
        d = {6'($urandom), 32'($urandom)};
        e = loop_expect(d, 1'b0);
        s0 = n_sdr1;
        run_scan(1'b1, 2'd3, d, r, lat);
        n_checks++;
        if (lat != 83) begin n_fail++; $display("FAIL th1_latency: got %0d want 83", lat); end
        n_checks++;
        if (r !== e) begin n_fail++; $display("FAIL th1_rsp: got %h want %h", r, e); end
        n_checks++;
        if (n_sdr1 - s0 != 38 || ir_in1 !== 2'd3) begin
            n_fail++; $display("FAIL th1_sdr_ir: sdr edges %0d ir_in %0d want 38/3", n_sdr1 - s0, ir_in1);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        logic [DR-1:0] a, b;
        int lat;
        use_stub = 1'b0;
        loop_seed = 1'b1;
        a = {6'($urandom), 32'($urandom)};
        b = {6'($urandom), 32'($urandom)};
        cmd_ir = 2'd1; exp_ir = 2'd1; cmd_data = a;
        cmd_valid = 1'b1;   // held high across both commands
        @(negedge clk);
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
        n_checks++;
        if (lat != 165 || rsp_data !== loop_expect(a, 1'b1)) begin
            n_fail++; $display("FAIL b2b_first: lat %0d data %h want 165 %h", lat, rsp_data, loop_expect(a, 1'b1));
        end
        cmd_data = b;
        @(negedge clk);
        n_checks++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready_after_rsp: got %b want 1", cmd_ready); end
        @(negedge clk);
        cmd_valid = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second_accept: busy=%b ready=%b want 1/0", busy, cmd_ready);
        end
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 2000) begin @(negedge clk); lat++; end
        n_checks++;
        if (lat != 165 || rsp_data !== loop_expect(b, 1'b1)) begin
            n_fail++; $display("FAIL b2b_second: lat %0d data %h want 165 %h", lat, rsp_data, loop_expect(b, 1'b1));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        logic [DR-1:0] d, r;
        int s0, r0, n, lat;
        use_stub = 1'b0;
        loop_seed = 1'b0;
        cmd_ir = 2'd3; exp_ir = 2'd3;
        cmd_data = {6'($urandom), 32'($urandom)};
        s0 = n_sdr;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (n_sdr - s0 < 17 && n < 2000) begin @(negedge clk); n++; end
        n_checks++;
        if (n_sdr - s0 != 17) begin n_fail++; $display("FAIL midreset_reach_bit17: sdr edges %0d want 17", n_sdr - s0); end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if (outs0() !== RST_OUTS || rsp_data !== '0) begin
            n_fail++;
            $display("FAIL midreset_values: outs=%b rsp_data=%h want outs=%b rsp_data=0", outs0(), rsp_data, RST_OUTS);
        end
        reset = 1'b0;
        r0 = n_rsp;
        repeat (200) @(negedge clk);
        n_checks++;
        if (n_rsp != r0) begin n_fail++; $display("FAIL midreset_no_rsp: got %0d responses want 0", n_rsp - r0); end
        d = {6'($urandom), 32'($urandom)};
        run_scan(1'b0, 2'd2, d, r, lat);
        n_checks++;
        if (lat != 165 || r !== loop_expect(d, 1'b0)) begin
            n_fail++; $display("FAIL midreset_recover: lat %0d data %h want 165 %h", lat, r, loop_expect(d, 1'b0));
        end
        @(negedge clk);
    endtask

    task automatic test_busy_ignore();
        logic [DR-1:0] d;
        logic [1:0] ir;
        int lat, r0, ib0;
        use_stub = 1'b0;
        loop_seed = 1'b1;
        ir = 2'($urandom);
        d = {6'($urandom), 32'($urandom)};
        cmd_ir = ir; exp_ir = ir; cmd_data = d;
        r0 = n_rsp; ib0 = ir_bad;
        cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 2000) begin
            if (lat == 40 || lat == 100) begin
                cmd_valid = 1'b1; cmd_ir = ~ir; cmd_data = ~d;
            end else begin
                cmd_valid = 1'b0; cmd_ir = ir; cmd_data = d;
            end
            @(negedge clk);
            lat++;
        end
        cmd_valid = 1'b0;
        n_checks++;
        if (lat != 165 || rsp_data !== loop_expect(d, 1'b1)) begin
            n_fail++; $display("FAIL busy_pulse_scan: lat %0d data %h want 165 %h", lat, rsp_data, loop_expect(d, 1'b1));
        end
        repeat (200) @(negedge clk);
        n_checks++;
        if (n_rsp - r0 != 1 || ir_bad != ib0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_pulse_ignored: responses %0d ir errors %0d busy %b want 1/0/0", n_rsp - r0, ir_bad - ib0, busy);
        end
    endtask

    task automatic test_random();
        logic [DR-1:0] d, r, e;
        logic [1:0] ir;
        int lat, s0, ib0;
        for (int i = 0; i < 8; i++) begin
            ir = 2'($urandom);
            d = {6'($urandom), 32'($urandom)};
            use_stub = 1'($urandom);
            loop_seed = 1'($urandom);
            stub_preset = {6'($urandom), 32'($urandom)};
            e = use_stub ? stub_preset : loop_expect(d, loop_seed);
            s0 = n_sdr; ib0 = ir_bad;
            run_scan(1'b0, ir, d, r, lat);
            n_checks++;
            if (lat != 165 || r !== e || n_sdr - s0 != 38 || ir_bad != ib0) begin
                n_fail++;
                $display("FAIL random_%0d: lat %0d rsp %h sdr %0d irerr %0d want 165 %h 38 0",
                         i, lat, r, n_sdr - s0, ir_bad - ib0, e);
            end
            @(negedge clk);
        end
        use_stub = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        cmd_valid = 1'b0;
        cmd_valid1 = 1'b0;
        cmd_ir = 2'd0;
        cmd_data = '0;
        use_stub = 1'b0;
        loop_seed = 1'b0;
        stub_preset = '0;
        @(negedge clk);
        test_reset();
        test_loopback();
        test_stub();
        test_latency_th1();
        test_back_to_back();
        test_reset_mid_scan();
        test_busy_ignore();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d checks %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
